// File: rtl/glb_sram_macro.sv
// Behavioural model of the generic single-port SRAM macro used by the GLB banks.
// Strobes are active-low and reads have one cycle of latency. Contents are never cleared.
module glb_sram_macro #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [DATA_WIDTH-1:0] BWEB,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  SLP
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge CLK) begin
    if (!CEB && !SLP) begin
      if (!WEB) begin
        r_mem[A] <= (r_mem[A] & BWEB) | (D & ~BWEB);
      end else begin
        Q <= r_mem[A];
      end
    end
  end

endmodule

// File: rtl/glb_bank_sram_tiled.sv
// GLB bank SRAM: tiles glb_sram_macro in rows and columns, with optional in/out pipelining,
// a ready/valid request handshake, a read-data-valid output and an idle-sleep power FSM.
module glb_bank_sram_tiled #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 14,
  parameter int MACRO_ADDR_WIDTH = 11,
  parameter int MACRO_DATA_WIDTH = 64,
  parameter int IN_PIPE          = 1,
  parameter int OUT_PIPE         = 0,
  parameter int IDLE_CYCLES      = 256,
  parameter int WAKE_CYCLES      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] bit_en,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_vld,
  input  logic                  sleep_en,
  output logic                  sram_sleep
);

  localparam int ROW_BITS   = (ADDR_WIDTH > MACRO_ADDR_WIDTH) ? ADDR_WIDTH - MACRO_ADDR_WIDTH : 0;
  localparam int NUM_ROW    = 1 << ROW_BITS;
  localparam int SEL_W      = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int NUM_COL    = (DATA_WIDTH + MACRO_DATA_WIDTH - 1) / MACRO_DATA_WIDTH;
  localparam int PAD_W      = NUM_COL * MACRO_DATA_WIDTH;
  localparam int CNT_MAX    = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int IDLE_LAST  = (IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0;
  localparam int WAKE_LAST  = (WAKE_CYCLES > 1) ? WAKE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_SLEEP,
    ST_WAKE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_idle_cnt, w_idle_nxt;
  logic [CNT_W-1:0]   r_wake_cnt, w_wake_nxt;
  logic               w_sleep;
  logic               w_req, w_acc, w_acc_wr, w_acc_rd;
  logic               w_busy;

  logic [SEL_W-1:0]            w_row;
  logic [MACRO_ADDR_WIDTH-1:0] w_maddr;
  logic [PAD_W-1:0]            w_wdata_pad, w_bwe_pad;

  logic                        w_s_wr, w_s_rd;
  logic [SEL_W-1:0]            w_s_row;
  logic [MACRO_ADDR_WIDTH-1:0] w_s_maddr;
  logic [PAD_W-1:0]            w_s_wdata, w_s_bwe;
  logic                        w_in_busy;

  logic [DATA_WIDTH-1:0]       w_q_row [NUM_ROW];
  logic [DATA_WIDTH-1:0]       w_mux;
  logic                        r_q_vld;
  logic [SEL_W-1:0]            r_q_row;
  logic                        w_out_busy;

  assign w_sleep    = (r_state == ST_SLEEP);
  assign sram_sleep = w_sleep;
  assign req_ready  = (r_state == ST_ACTIVE);

  // Write wins a simultaneous ren/wen: the read half is simply not issued.
  assign w_req    = ren | wen;
  assign w_acc    = w_req & (r_state == ST_ACTIVE);
  assign w_acc_wr = w_acc & wen;
  assign w_acc_rd = w_acc & ren & ~wen;

  assign w_wdata_pad = PAD_W'(wdata);
  assign w_bwe_pad   = PAD_W'(bit_en);

  if (ROW_BITS > 0) begin : g_rsel
    assign w_row   = addr[ADDR_WIDTH-1:MACRO_ADDR_WIDTH];
    assign w_maddr = addr[MACRO_ADDR_WIDTH-1:0];
  end else begin : g_rsel_one
    assign w_row   = '0;
    assign w_maddr = MACRO_ADDR_WIDTH'(addr);
  end

  if (IN_PIPE != 0) begin : g_in_pipe
    logic                        r_in_wr, r_in_rd;
    logic [SEL_W-1:0]            r_in_row;
    logic [MACRO_ADDR_WIDTH-1:0] r_in_maddr;
    logic [PAD_W-1:0]            r_in_wdata, r_in_bwe;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_in_wr    <= 1'b0;
        r_in_rd    <= 1'b0;
        r_in_row   <= '0;
        r_in_maddr <= '0;
        r_in_wdata <= '0;
        r_in_bwe   <= '0;
      end else begin
        r_in_wr <= w_acc_wr;
        r_in_rd <= w_acc_rd;
        if (w_acc) begin
          r_in_row   <= w_row;
          r_in_maddr <= w_maddr;
          r_in_wdata <= w_wdata_pad;
          r_in_bwe   <= w_bwe_pad;
        end
      end
    end

    assign w_s_wr    = r_in_wr;
    assign w_s_rd    = r_in_rd;
    assign w_s_row   = r_in_row;
    assign w_s_maddr = r_in_maddr;
    assign w_s_wdata = r_in_wdata;
    assign w_s_bwe   = r_in_bwe;
    assign w_in_busy = r_in_wr | r_in_rd;
  end else begin : g_in_comb
    assign w_s_wr    = w_acc_wr;
    assign w_s_rd    = w_acc_rd;
    assign w_s_row   = w_row;
    assign w_s_maddr = w_maddr;
    assign w_s_wdata = w_wdata_pad;
    assign w_s_bwe   = w_bwe_pad;
    assign w_in_busy = 1'b0;
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    logic             w_ceb;
    logic [PAD_W-1:0] w_q_cat;

    assign w_ceb = ~((w_s_wr | w_s_rd) & (w_s_row == SEL_W'(r)) & ~w_sleep);

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      glb_sram_macro #(
        .ADDR_WIDTH (MACRO_ADDR_WIDTH),
        .DATA_WIDTH (MACRO_DATA_WIDTH)
      ) u_macro (
        .CLK  (clk),
        .CEB  (w_ceb),
        .WEB  (~w_s_wr),
        .BWEB (~w_s_bwe[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .A    (w_s_maddr),
        .D    (w_s_wdata[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .Q    (w_q_cat[c*MACRO_DATA_WIDTH +: MACRO_DATA_WIDTH]),
        .SLP  (w_sleep)
      );
    end

    assign w_q_row[r] = w_q_cat[DATA_WIDTH-1:0];

    if (PAD_W > DATA_WIDTH) begin : g_pad
      logic [PAD_W-DATA_WIDTH-1:0] w_unused_q;
      assign w_unused_q = w_q_cat[PAD_W-1:DATA_WIDTH];
    end
  end

  // Row tag only advances on reads, so interleaved writes leave the mux pointing at the last read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q_vld <= 1'b0;
      r_q_row <= '0;
    end else begin
      r_q_vld <= w_s_rd;
      if (w_s_rd) begin
        r_q_row <= w_s_row;
      end
    end
  end

  always_comb begin
    w_mux = '0;
    for (int unsigned r = 0; r < NUM_ROW; r++) begin
      if (r_q_row == SEL_W'(r)) begin
        w_mux = w_q_row[r];
      end
    end
  end

  if (OUT_PIPE != 0) begin : g_out_pipe
    logic                  r_out_vld;
    logic [DATA_WIDTH-1:0] r_out_data;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out_vld  <= 1'b0;
        r_out_data <= '0;
      end else begin
        r_out_vld <= r_q_vld;
        if (r_q_vld) begin
          r_out_data <= w_mux;
        end
      end
    end

    assign rdata      = r_out_data;
    assign rdata_vld  = r_out_vld;
    assign w_out_busy = r_out_vld;
  end else begin : g_out_comb
    logic [DATA_WIDTH-1:0] r_hold;

    // Macro Q can move on later accesses, so a shadow copy keeps rdata stable between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_hold <= '0;
      end else if (r_q_vld) begin
        r_hold <= w_mux;
      end
    end

    assign rdata      = r_q_vld ? w_mux : r_hold;
    assign rdata_vld  = r_q_vld;
    assign w_out_busy = 1'b0;
  end

  assign w_busy = w_in_busy | r_q_vld | w_out_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_wake_nxt  = '0;
    case (r_state)
      ST_ACTIVE: begin
        if (w_acc || w_busy) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt != CNT_W'(IDLE_LAST)) begin
          w_idle_nxt = r_idle_cnt + CNT_W'(1);
        end
        if (sleep_en && (IDLE_CYCLES != 0) && (r_idle_cnt == CNT_W'(IDLE_LAST)) &&
            !w_acc && !w_busy) begin
          w_state_nxt = ST_SLEEP;
          w_idle_nxt  = '0;
        end
      end
      ST_SLEEP: begin
        w_idle_nxt = '0;
        if (w_req || !sleep_en) begin
          w_state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        w_idle_nxt = '0;
        if (r_wake_cnt == CNT_W'(WAKE_LAST)) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_wake_nxt = r_wake_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_ACTIVE;
        w_idle_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_glb_bank_sram_tiled.sv
// Directed bench for glb_bank_sram_tiled: default config, a 96-bit/IN0/OUT1 config and a
// short-idle sleep config, all sharing one clock and reset.
module tb_glb_bank_sram_tiled;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        ren_v   [3];
  logic        wen_v   [3];
  logic [13:0] addr_v  [3];
  logic [95:0] wdata_v [3];
  logic [95:0] ben_v   [3];
  logic        sen_v   [3];
  logic        rdy     [3];
  logic        vld     [3];
  logic        slp     [3];
  logic [63:0] rd_a, rd_c;
  logic [95:0] rd_b;

  int n_tests = 0;
  int n_fail  = 0;

  glb_bank_sram_tiled u_dut_a (
    .clk(clk), .reset_n(reset_n), .ren(ren_v[0]), .wen(wen_v[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0][63:0]), .bit_en(ben_v[0][63:0]), .req_ready(rdy[0]), .rdata(rd_a),
    .rdata_vld(vld[0]), .sleep_en(sen_v[0]), .sram_sleep(slp[0])
  );

  glb_bank_sram_tiled #(
    .DATA_WIDTH(96), .MACRO_DATA_WIDTH(64), .IN_PIPE(0), .OUT_PIPE(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .ren(ren_v[1]), .wen(wen_v[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .bit_en(ben_v[1]), .req_ready(rdy[1]), .rdata(rd_b),
    .rdata_vld(vld[1]), .sleep_en(sen_v[1]), .sram_sleep(slp[1])
  );

  glb_bank_sram_tiled #(
    .IDLE_CYCLES(8), .WAKE_CYCLES(4)
  ) u_dut_c (
    .clk(clk), .reset_n(reset_n), .ren(ren_v[2]), .wen(wen_v[2]), .addr(addr_v[2]),
    .wdata(wdata_v[2][63:0]), .bit_en(ben_v[2][63:0]), .req_ready(rdy[2]), .rdata(rd_c),
    .rdata_vld(vld[2]), .sleep_en(sen_v[2]), .sram_sleep(slp[2])
  );

  function automatic logic [95:0] get_rdata(input int d);
    case (d)
      0:       return {32'd0, rd_a};
      1:       return rd_b;
      default: return {32'd0, rd_c};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [13:0] a,
                       input logic [95:0] wd, input logic [95:0] be, output int waited);
    ren_v[d]   = r;
    wen_v[d]   = w;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    ben_v[d]   = be;
    waited     = 0;
    @(negedge clk);
    while (!rdy[d] && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk($sformatf("accept_d%0d", d), {95'd0, rdy[d]}, 96'd1);
    @(posedge clk); #1;
    ren_v[d] = 1'b0;
    wen_v[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [13:0] a, input logic [95:0] wd,
                    input logic [95:0] be);
    int w;
    drive(d, 1'b0, 1'b1, a, wd, be, w);
  endtask

  task automatic rd_check(input int d, input logic [13:0] a, input logic [95:0] exp,
                          input int lat, input string tag);
    int w;
    drive(d, 1'b1, 1'b0, a, '0, '0, w);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("%s_vld%0d", tag, k), {95'd0, vld[d]}, {95'd0, 1'(k == lat)});
      if (k == lat) chk($sformatf("%s_data", tag), get_rdata(d), exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    for (int d = 0; d < 3; d++) begin
      ren_v[d] = 1'b0; wen_v[d] = 1'b0; addr_v[d] = '0;
      wdata_v[d] = '0; ben_v[d] = '0;
    end
    sen_v[0] = 1'b0; sen_v[1] = 1'b0; sen_v[2] = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state of every instance
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rdata_d%0d", d), get_rdata(d), 96'd0);
      chk($sformatf("rst_vld_d%0d", d), {95'd0, vld[d]}, 96'd0);
      chk($sformatf("rst_sleep_d%0d", d), {95'd0, slp[d]}, 96'd0);
      chk($sformatf("rst_ready_d%0d", d), {95'd0, rdy[d]}, 96'd1);
    end
    @(posedge clk); #1;

    // Sleep instance: 8 idle cycles after the write drains, then SLEEP
    wr(2, 14'h0000, 96'h1111_2222_3333_4444, '1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("slp_enter%0d", k), {95'd0, slp[2]}, {95'd0, 1'(k == 10)});
      chk($sformatf("slp_ready%0d", k), {95'd0, rdy[2]}, {95'd0, 1'(k != 10)});
    end
    @(negedge clk);
    chk("slp_hold", {95'd0, slp[2]}, 96'd1);
    @(posedge clk); #1;
    drive(2, 1'b1, 1'b0, 14'h0000, '0, '0, waited);
    chk("slp_wait_cycles", 96'(waited), 96'd5);
    chk("slp_after_wake", {95'd0, slp[2]}, 96'd0);
    @(negedge clk);
    chk("slp_rd_vld1", {95'd0, vld[2]}, 96'd0);
    @(negedge clk);
    chk("slp_rd_vld2", {95'd0, vld[2]}, 96'd1);
    chk("slp_rd_data", get_rdata(2), 96'h1111_2222_3333_4444);
    @(posedge clk); #1;

    // Default: two writes then back-to-back reads
    wr(0, 14'h0000, 96'h0123_4567_89AB_CDEF, '1);
    wr(0, 14'h3FFF, 96'hFEDC_BA98_7654_3210, '1);
    drive(0, 1'b1, 1'b0, 14'h0000, '0, '0, waited);
    chk("b2b_vld_acc1", {95'd0, vld[0]}, 96'd0);
    drive(0, 1'b1, 1'b0, 14'h3FFF, '0, '0, waited);
    @(negedge clk);
    chk("b2b_vld0", {95'd0, vld[0]}, 96'd1);
    chk("b2b_data0", get_rdata(0), 96'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("b2b_vld1", {95'd0, vld[0]}, 96'd1);
    chk("b2b_data1", get_rdata(0), 96'hFEDC_BA98_7654_3210);
    @(negedge clk);
    chk("b2b_vld_end", {95'd0, vld[0]}, 96'd0);
    chk("b2b_hold", get_rdata(0), 96'hFEDC_BA98_7654_3210);
    @(posedge clk); #1;

    // Per-bit enable into row 1; row 0 untouched
    wr(0, 14'h0800, 96'd0, '1);
    wr(0, 14'h0800, 96'hFFFF_FFFF_FFFF_FFFF, 96'h0000_0000_FFFF_FFFF);
    rd_check(0, 14'h0800, 96'h0000_0000_FFFF_FFFF, 2, "biten_row1");
    rd_check(0, 14'h0000, 96'h0123_4567_89AB_CDEF, 2, "biten_row0");

    // Simultaneous ren/wen: the write wins and no read result appears
    drive(0, 1'b1, 1'b1, 14'h0005, 96'h77, '1, waited);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rw_novld%0d", k), {95'd0, vld[0]}, 96'd0);
    end
    @(posedge clk); #1;
    rd_check(0, 14'h0005, 96'h77, 2, "rw_readback");

    // 96-bit, two columns, IN_PIPE=0 OUT_PIPE=1
    wr(1, 14'h1234, {12{8'hA5}}, '1);
    rd_check(1, 14'h1234, {12{8'hA5}}, 2, "w96_read");
    wr(1, 14'h1234, '1, 96'hFFFF_FFFF_0000_0000_0000_0000);
    rd_check(1, 14'h1234, 96'hFFFF_FFFF_A5A5_A5A5_A5A5_A5A5, 2, "w96_col1");

    // Reset with two reads in flight
    ren_v[0] = 1'b1; addr_v[0] = 14'h0000;
    @(posedge clk); #1;
    addr_v[0] = 14'h3FFF;
    @(posedge clk); #1;
    ren_v[0] = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld", {95'd0, vld[0]}, 96'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_drop_vld%0d", k), {95'd0, vld[0]}, 96'd0);
      chk($sformatf("rst_drop_data%0d", k), get_rdata(0), 96'd0);
      chk($sformatf("rst_drop_ready%0d", k), {95'd0, rdy[0]}, 96'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
